eco32_core_lsu_dcu_xfer: RTL and testbench
==========================================

# eco32_core_lsu_dcu_xfer

Line transfer engine for the data-cache unit: drives the external (x-side) port of the DCU byte memory to move whole 8-byte lines between the cache and the memory bus. On a flush it reads the 8 bytes and their dirty bits (ben), packs them into one 64-bit write with byte enables, and skips the bus write when the line is clean. On a fill it accepts one 64-bit word from the bus and writes it byte-by-byte, which clears every dirty bit. It sits between the LSU miss/evict control and the DCU memory x-port.

## Interface
Parameters:
- PAGE_ADDR_WIDTH, 5, page index width; must match the DCU memory.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req_stb  in  1  request strobe, single cycle, sampled only in IDLE
- i_req_op  in  1  0=FILL, 1=FLUSH
- i_req_tid  in  1  thread id of line
- i_req_wid  in  1  way id of line
- i_req_page  in  PAGE_ADDR_WIDTH  page index of line
- o_req_ack  out  1  combinational: i_req_stb && state==IDLE
- o_busy  out  1  state!=IDLE
- o_done  out  1  one-cycle pulse at end of transfer
- o_done_wb  out  1  valid with o_done: 1 if a bus write was issued
- m_stb  out  1  x-port strobe
- m_wen  out  1  x-port write enable (qualified by m_stb)
- m_tid, m_wid  out  1 each  latched line tid/wid
- m_page  out  PAGE_ADDR_WIDTH  latched page
- m_offset  out  3  byte offset
- m_data  out  8  write byte
- m_val  in  1  read data valid, one cycle after a read strobe
- m_ben  in  1  dirty bit of returned byte
- m_rdata  in  8  returned byte
- o_wr_stb  out  1  bus write request, held until i_wr_ack
- o_wr_data  out  64  byte n at [8n+7:8n]
- o_wr_ben  out  8  byte enables = collected dirty bits
- i_wr_ack  in  1  bus write accepted
- o_rd_rdy  out  1  ready for fill word
- i_rd_stb  in  1  fill word valid; consumed when o_rd_rdy
- i_rd_data  in  64  fill word, byte n at [8n+7:8n]

## Operation
- States: IDLE, RD_ISSUE, RD_DRAIN, WR_REQ, FILL_WAIT, FILL_WR, DONE.
- IDLE: on i_req_stb, latch tid/wid/page/op. FLUSH goes to RD_ISSUE, FILL goes to FILL_WAIT. Clear the collect registers (data=0, ben=0).
- RD_ISSUE: m_stb=1, m_wen=0, m_offset = issue counter 0..7. After offset 7, go to RD_DRAIN.
- Receive counter (3 bit) advances on each m_val. Byte k stores m_rdata into data[k] and m_ben into ben[k]. This runs independently of the issue counter.
- RD_DRAIN: wait for the 8th m_val. Then go to WR_REQ if |ben, else DONE with o_done_wb=0.
- WR_REQ: o_wr_stb=1 with stable data/ben until i_wr_ack. Then go to DONE with o_done_wb=1.
- FILL_WAIT: o_rd_rdy=1. On i_rd_stb, latch i_rd_data and go to FILL_WR.
- FILL_WR: m_stb=1, m_wen=1, offset 0..7 over 8 cycles, m_data = byte[offset]. Then go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Flush does not clear dirty bits. The caller must follow an eviction with a fill or discard the line.
- Outside RD_ISSUE and FILL_WR, m_stb=0. m_offset and m_data are then don't-care but are driven 0.
- Counters are 3 bits and wrap; state exit is decided at count 7, never on wrap.

## Timing
- Reset values: every output 0 and state IDLE. m_tid/m_wid/m_page/m_offset/m_data are 0.
- Flush, dirty: request at T0 (ack), reads T1–T8, m_val T2–T9, o_wr_stb from T10. If ack arrives at Ta, o_done is at Ta+1.
- Flush, clean: o_done at T10, o_wr_stb never asserted.
- Fill: o_rd_rdy from T1. If i_rd_stb arrives at Tr, writes occur Tr+1..Tr+8 and o_done is at Tr+9.
- i_wr_ack in the same cycle o_wr_stb first rises is accepted: minimum one WR_REQ cycle.
- i_req_stb while busy is ignored (ack=0), and is not queued.
- i_rd_stb outside FILL_WAIT and i_wr_ack outside WR_REQ are ignored.
- Reset mid-operation: immediate return to IDLE with no o_done. A partial fill may leave a line mixed; the caller re-issues.
- Throughput: back-to-back request is accepted in the cycle after DONE.

## Structure
- Shared package eco32_core_lsu_dcu_pkg holds:
  - op encoding constants (DCU_OP_FILL=0, DCU_OP_FLUSH=1);
  - state encoding;
  - DCU_LINE_BYTES=8 and the 3-bit offset width.
- Single module, no sub-module needed.

## Test plan
- Flush of dirty line: preload bytes 0x10..0x17, ben=8'b1010_0101 -> o_wr_data=0x1716151413121110 with o_wr_ben=8'hA5. i_wr_ack at T12 gives o_done at T13 with o_done_wb=1.
- Flush of clean line (all ben=0) -> no o_wr_stb; o_done at T10 with o_done_wb=0.
- Fill with i_rd_data=0x8877665544332211, i_rd_stb 3 cycles after o_rd_rdy -> 8 writes offsets 0..7, data 0x11..0x88. A following flush then reads ben=0 for all bytes.
- Request during busy -> o_req_ack=0 and no state disturbance; a request in the cycle after o_done is acked.
- rst asserted mid-RD_ISSUE (offset 4) -> all outputs 0 next edge, no o_done. A new flush then completes normally.
- Back-to-back flush then fill on different page/wid/tid -> m_page/m_wid/m_tid switch only at the new ack; data is correct for both.

Source files
------------

// File: rtl/eco32_core_lsu_dcu_pkg.sv
// Shared definitions for the LSU data-cache line transfer engine.
package eco32_core_lsu_dcu_pkg;

    localparam int DCU_LINE_BYTES   = 8;
    localparam int DCU_OFFSET_WIDTH = 3;
    localparam int DCU_LINE_BITS    = DCU_LINE_BYTES * 8;

    localparam logic DCU_OP_FILL  = 1'b0;
    localparam logic DCU_OP_FLUSH = 1'b1;

    typedef logic [DCU_OFFSET_WIDTH-1:0] dcu_offset_t;

    // Last byte offset in a line; counters leave their state here, never on wrap.
    localparam dcu_offset_t DCU_OFFSET_LAST = dcu_offset_t'(DCU_LINE_BYTES - 1);

    typedef enum logic [2:0] {
        XFER_IDLE      = 3'd0,
        XFER_RD_ISSUE  = 3'd1,
        XFER_RD_DRAIN  = 3'd2,
        XFER_WR_REQ    = 3'd3,
        XFER_FILL_WAIT = 3'd4,
        XFER_FILL_WR   = 3'd5,
        XFER_DONE      = 3'd6
    } dcu_xfer_state_e;

    // Select byte 'off' of a packed line (byte n lives at [8n+7:8n]).
    function automatic logic [7:0] dcu_line_byte(input logic [DCU_LINE_BITS-1:0] line,
                                                 input dcu_offset_t off);
        return line[8*off +: 8];
    endfunction

    // One-hot byte-enable for byte 'off'.
    function automatic logic [DCU_LINE_BYTES-1:0] dcu_byte_mask(input dcu_offset_t off);
        return {{(DCU_LINE_BYTES-1){1'b0}}, 1'b1} << off;
    endfunction

endpackage

// File: rtl/eco32_core_lsu_dcu_xfer.sv
// Line transfer engine between the DCU byte memory x-port and the memory bus.
// Flush: read 8 bytes + dirty bits, issue one masked 64-bit write if any byte is dirty.
// Fill:  take one 64-bit word from the bus and write it byte-by-byte (clears dirty bits).
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | waiting for a request; request is acked combinationally
// RD_ISSUE   | issuing 8 byte reads on the x-port, offsets 0..7
// RD_DRAIN   | reads issued, waiting for the 8th returned byte
// WR_REQ     | bus write requested, holding data/ben until acked
// FILL_WAIT  | ready for the fill word from the bus
// FILL_WR    | writing the fill word into the line, offsets 0..7
// DONE       | one-cycle completion pulse
module eco32_core_lsu_dcu_xfer
    import eco32_core_lsu_dcu_pkg::*;
#(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       i_req_stb,
    input  logic                       i_req_op,
    input  logic                       i_req_tid,
    input  logic                       i_req_wid,
    input  logic [PAGE_ADDR_WIDTH-1:0] i_req_page,
    output logic                       o_req_ack,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_done_wb,

    output logic                       m_stb,
    output logic                       m_wen,
    output logic                       m_tid,
    output logic                       m_wid,
    output logic [PAGE_ADDR_WIDTH-1:0] m_page,
    output logic [2:0]                 m_offset,
    output logic [7:0]                 m_data,
    input  logic                       m_val,
    input  logic                       m_ben,
    input  logic [7:0]                 m_rdata,

    output logic                       o_wr_stb,
    output logic [63:0]                o_wr_data,
    output logic [7:0]                 o_wr_ben,
    input  logic                       i_wr_ack,

    output logic                       o_rd_rdy,
    input  logic                       i_rd_stb,
    input  logic [63:0]                i_rd_data
);

    dcu_xfer_state_e            state;
    dcu_offset_t                cnt;
    dcu_offset_t                rcv_cnt;
    logic                       rcv_all;
    logic                       wb_flag;
    logic                       line_tid;
    logic                       line_wid;
    logic [PAGE_ADDR_WIDTH-1:0] line_page;
    logic [DCU_LINE_BITS-1:0]   col_data;
    logic [DCU_LINE_BYTES-1:0]  col_ben;
    logic [DCU_LINE_BITS-1:0]   fill_word;

    logic                       req_take;
    logic                       rcv_phase;
    logic                       rcv_take;
    logic                       last_byte;
    logic [DCU_LINE_BYTES-1:0]  ben_final;

    // Request handshake and read-return qualification.
    always_comb begin
        req_take  = i_req_stb && (state == XFER_IDLE);
        rcv_phase = (state == XFER_RD_ISSUE) || (state == XFER_RD_DRAIN);
        rcv_take  = rcv_phase && m_val;
        last_byte = rcv_take && (rcv_cnt == DCU_OFFSET_LAST);
        // Dirty set including a byte returning this very cycle, so the
        // write/skip decision does not need an extra cycle.
        ben_final = col_ben | ((last_byte && m_ben) ? dcu_byte_mask(rcv_cnt) : '0);
    end

    // Transfer sequencer: state, issue/write counter and latched line identity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= XFER_IDLE;
            cnt       <= '0;
            wb_flag   <= 1'b0;
            line_tid  <= 1'b0;
            line_wid  <= 1'b0;
            line_page <= '0;
            fill_word <= '0;
        end else begin
            case (state)
                XFER_IDLE: begin
                    if (i_req_stb) begin
                        line_tid  <= i_req_tid;
                        line_wid  <= i_req_wid;
                        line_page <= i_req_page;
                        wb_flag   <= 1'b0;
                        cnt       <= '0;
                        state     <= (i_req_op == DCU_OP_FLUSH) ? XFER_RD_ISSUE : XFER_FILL_WAIT;
                    end
                end
                XFER_RD_ISSUE: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == DCU_OFFSET_LAST) begin
                        state <= XFER_RD_DRAIN;
                    end
                end
                XFER_RD_DRAIN: begin
                    // rcv_all covers a memory that returns all bytes before draining starts.
                    if (last_byte || rcv_all) begin
                        state <= (|ben_final) ? XFER_WR_REQ : XFER_DONE;
                    end
                end
                XFER_WR_REQ: begin
                    if (i_wr_ack) begin
                        wb_flag <= 1'b1;
                        state   <= XFER_DONE;
                    end
                end
                XFER_FILL_WAIT: begin
                    if (i_rd_stb) begin
                        fill_word <= i_rd_data;
                        cnt       <= '0;
                        state     <= XFER_FILL_WR;
                    end
                end
                XFER_FILL_WR: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == DCU_OFFSET_LAST) begin
                        state <= XFER_DONE;
                    end
                end
                XFER_DONE: begin
                    state <= XFER_IDLE;
                end
                default: begin
                    state <= XFER_IDLE;
                end
            endcase
        end
    end

    // Read-return collector: runs on its own counter, decoupled from issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv_cnt  <= '0;
            rcv_all  <= 1'b0;
            col_data <= '0;
            col_ben  <= '0;
        end else if (req_take) begin
            rcv_cnt  <= '0;
            rcv_all  <= 1'b0;
            col_data <= '0;
            col_ben  <= '0;
        end else if (rcv_take && !rcv_all) begin
            col_data[8*rcv_cnt +: 8] <= m_rdata;
            col_ben[rcv_cnt]         <= m_ben;
            rcv_cnt                  <= rcv_cnt + 3'd1;
            if (rcv_cnt == DCU_OFFSET_LAST) begin
                rcv_all <= 1'b1;
            end
        end
    end

    // Output decode from registered state; idle x-port fields are driven 0.
    always_comb begin
        o_req_ack = req_take;
        o_busy    = (state != XFER_IDLE);
        o_done    = (state == XFER_DONE);
        o_done_wb = (state == XFER_DONE) && wb_flag;
        m_stb     = (state == XFER_RD_ISSUE) || (state == XFER_FILL_WR);
        m_wen     = (state == XFER_FILL_WR);
        m_tid     = line_tid;
        m_wid     = line_wid;
        m_page    = line_page;
        m_offset  = m_stb ? cnt : 3'd0;
        m_data    = (state == XFER_FILL_WR) ? dcu_line_byte(fill_word, cnt) : 8'h00;
        o_wr_stb  = (state == XFER_WR_REQ);
        o_wr_data = col_data;
        o_wr_ben  = col_ben;
        o_rd_rdy  = (state == XFER_FILL_WAIT);
    end

endmodule

// File: tb/tb_eco32_core_lsu_dcu_xfer.sv
// Directed bench for the DCU line transfer engine with a small x-port memory model.
module tb_eco32_core_lsu_dcu_xfer;

    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req_stb = 1'b0;
    logic          i_req_op = 1'b0;
    logic          i_req_tid = 1'b0;
    logic          i_req_wid = 1'b0;
    logic [PW-1:0] i_req_page = '0;
    logic          o_req_ack, o_busy, o_done, o_done_wb;
    logic          m_stb, m_wen, m_tid, m_wid;
    logic [PW-1:0] m_page;
    logic [2:0]    m_offset;
    logic [7:0]    m_data;
    logic          m_val = 1'b0;
    logic          m_ben = 1'b0;
    logic [7:0]    m_rdata = 8'h00;
    logic          o_wr_stb;
    logic [63:0]   o_wr_data;
    logic [7:0]    o_wr_ben;
    logic          i_wr_ack = 1'b0;
    logic          o_rd_rdy;
    logic          i_rd_stb = 1'b0;
    logic [63:0]   i_rd_data = '0;

    logic          cpu_we = 1'b0;
    logic [9:0]    cpu_addr = '0;
    logic [7:0]    cpu_data = '0;
    logic          cpu_ben = 1'b0;

    bit   [7:0]    mem_data [0:1023];
    bit            mem_ben  [0:1023];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    eco32_core_lsu_dcu_xfer #(.PAGE_ADDR_WIDTH(PW)) dut (
        .clk(clk), .rst(rst),
        .i_req_stb(i_req_stb), .i_req_op(i_req_op), .i_req_tid(i_req_tid),
        .i_req_wid(i_req_wid), .i_req_page(i_req_page),
        .o_req_ack(o_req_ack), .o_busy(o_busy), .o_done(o_done), .o_done_wb(o_done_wb),
        .m_stb(m_stb), .m_wen(m_wen), .m_tid(m_tid), .m_wid(m_wid), .m_page(m_page),
        .m_offset(m_offset), .m_data(m_data), .m_val(m_val), .m_ben(m_ben), .m_rdata(m_rdata),
        .o_wr_stb(o_wr_stb), .o_wr_data(o_wr_data), .o_wr_ben(o_wr_ben), .i_wr_ack(i_wr_ack),
        .o_rd_rdy(o_rd_rdy), .i_rd_stb(i_rd_stb), .i_rd_data(i_rd_data)
    );

    // DCU byte memory model: one-cycle read latency, x-port writes clear dirty,
    // plus a CPU-side preload port that sets data and dirty directly.
    always @(posedge clk) begin
        m_val <= 1'b0;
        if (m_stb && !m_wen) begin
            m_val   <= 1'b1;
            m_rdata <= mem_data[{m_tid, m_wid, m_page, m_offset}];
            m_ben   <= mem_ben[{m_tid, m_wid, m_page, m_offset}];
        end
        if (m_stb && m_wen) begin
            mem_data[{m_tid, m_wid, m_page, m_offset}] <= m_data;
            mem_ben[{m_tid, m_wid, m_page, m_offset}]  <= 1'b0;
        end
        if (cpu_we) begin
            mem_data[cpu_addr] <= cpu_data;
            mem_ben[cpu_addr]  <= cpu_ben;
        end
    end

    task automatic preload(input logic tid, input logic wid, input logic [PW-1:0] page,
                           input logic [63:0] data, input logic [7:0] ben);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cpu_we   = 1'b1;
            cpu_addr = {tid, wid, page, 3'(k)};
            cpu_data = data[8*k +: 8];
            cpu_ben  = ben[k];
        end
        @(negedge clk);
        cpu_we = 1'b0;
    endtask

    task automatic drive_req(input logic op, input logic tid, input logic wid, input logic [PW-1:0] page);
        i_req_stb  = 1'b1;
        i_req_op   = op;
        i_req_tid  = tid;
        i_req_wid  = wid;
        i_req_page = page;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk); #1;
        tot_cnt++; if ({o_busy, o_done, o_done_wb, m_stb, m_wen, m_tid, m_wid, o_wr_stb, o_rd_rdy, o_req_ack} !== 10'b0)
            $display("FAIL reset_ctrl got=%b want=0", {o_busy, o_done, o_done_wb, m_stb, m_wen, m_tid, m_wid, o_wr_stb, o_rd_rdy, o_req_ack}); else pass_cnt++;
        tot_cnt++; if ({m_page, m_offset, m_data, o_wr_ben, o_wr_data} !== '0)
            $display("FAIL reset_data got=%h want=0", {m_page, m_offset, m_data, o_wr_ben, o_wr_data}); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk); #1;
        tot_cnt++; if ({o_busy, o_done, m_stb} !== 3'b000) $display("FAIL reset_release got=%b want=000", {o_busy, o_done, m_stb}); else pass_cnt++;
    endtask

    task automatic test_flush_dirty();
        preload(1'b0, 1'b0, 5'd3, 64'h1716151413121110, 8'hA5);
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd3); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL fd_ack got=%b want=1", o_req_ack); else pass_cnt++;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk); i_req_stb = 1'b0; #1;
            tot_cnt++; if ({m_stb, m_wen, m_offset, m_page} !== {1'b1, 1'b0, 3'(t-1), 5'd3})
                $display("FAIL fd_read_t%0d got=%b want=%b", t, {m_stb, m_wen, m_offset, m_page}, {1'b1, 1'b0, 3'(t-1), 5'd3}); else pass_cnt++;
        end
        @(negedge clk); #1;
        tot_cnt++; if ({m_stb, o_wr_stb, o_busy} !== 3'b001) $display("FAIL fd_drain got=%b want=001", {m_stb, o_wr_stb, o_busy}); else pass_cnt++;
        @(negedge clk); #1;
        tot_cnt++; if ({o_wr_stb, o_wr_ben, o_wr_data} !== {1'b1, 8'hA5, 64'h1716151413121110})
            $display("FAIL fd_wr_t10 got=%b/%h/%h want=1/a5/1716151413121110", o_wr_stb, o_wr_ben, o_wr_data); else pass_cnt++;
        @(negedge clk); #1;
        tot_cnt++; if ({o_wr_stb, o_done} !== 2'b10) $display("FAIL fd_hold_t11 got=%b want=10", {o_wr_stb, o_done}); else pass_cnt++;
        @(negedge clk); i_wr_ack = 1'b1; #1;
        tot_cnt++; if ({o_wr_stb, o_wr_ben} !== {1'b1, 8'hA5}) $display("FAIL fd_hold_t12 got=%b/%h want=1/a5", o_wr_stb, o_wr_ben); else pass_cnt++;
        @(negedge clk); i_wr_ack = 1'b0; #1;
        tot_cnt++; if ({o_done, o_done_wb, o_wr_stb} !== 3'b110) $display("FAIL fd_done_t13 got=%b want=110", {o_done, o_done_wb, o_wr_stb}); else pass_cnt++;
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_busy} !== 2'b00) $display("FAIL fd_idle_t14 got=%b want=00", {o_done, o_busy}); else pass_cnt++;
    endtask

    task automatic test_flush_clean();
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd5); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL fc_ack got=%b want=1", o_req_ack); else pass_cnt++;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk); i_req_stb = 1'b0; #1;
            tot_cnt++; if ({o_wr_stb, o_done} !== 2'b00) $display("FAIL fc_quiet_t%0d got=%b want=00", t, {o_wr_stb, o_done}); else pass_cnt++;
        end
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_done_wb, o_wr_stb, o_wr_ben} !== {3'b100, 8'h00})
            $display("FAIL fc_done_t10 got=%b/%h want=100/00", {o_done, o_done_wb, o_wr_stb}, o_wr_ben); else pass_cnt++;
        @(negedge clk); #1;
        tot_cnt++; if (o_busy !== 1'b0) $display("FAIL fc_idle got=%b want=0", o_busy); else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [7:0] exp_byte;
        @(negedge clk); drive_req(1'b0, 1'b0, 1'b0, 5'd3); i_wr_ack = 1'b1; #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL fi_ack got=%b want=1", o_req_ack); else pass_cnt++;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk); i_req_stb = 1'b0; i_wr_ack = 1'b0; #1;
            tot_cnt++; if ({o_rd_rdy, m_stb, o_wr_stb} !== 3'b100) $display("FAIL fi_wait_t%0d got=%b want=100", t, {o_rd_rdy, m_stb, o_wr_stb}); else pass_cnt++;
        end
        @(negedge clk); i_rd_stb = 1'b1; i_rd_data = 64'h8877665544332211; #1;
        tot_cnt++; if (o_rd_rdy !== 1'b1) $display("FAIL fi_rdy_t4 got=%b want=1", o_rd_rdy); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); i_rd_stb = 1'b0; i_rd_data = '0; #1;
            exp_byte = 8'((k + 1) * 17);
            tot_cnt++; if ({m_stb, m_wen, m_offset, m_data} !== {1'b1, 1'b1, 3'(k), exp_byte})
                $display("FAIL fi_write_%0d got=%b/%0d/%h want=11/%0d/%h", k, {m_stb, m_wen}, m_offset, m_data, k, exp_byte); else pass_cnt++;
        end
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_done_wb, m_stb} !== 3'b100) $display("FAIL fi_done got=%b want=100", {o_done, o_done_wb, m_stb}); else pass_cnt++;
        // Re-flush the same line: the fill must have cleared every dirty bit.
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd3); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL fi_reflush_ack got=%b want=1", o_req_ack); else pass_cnt++;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk); i_req_stb = 1'b0;
        end
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_done_wb, o_wr_ben, o_wr_data} !== {2'b10, 8'h00, 64'h8877665544332211})
            $display("FAIL fi_reflush got=%b/%h/%h want=10/00/8877665544332211", {o_done, o_done_wb}, o_wr_ben, o_wr_data); else pass_cnt++;
    endtask

    task automatic test_busy_req();
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd5); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL br_ack got=%b want=1", o_req_ack); else pass_cnt++;
        @(negedge clk); i_req_stb = 1'b0;
        @(negedge clk);
        @(negedge clk); drive_req(1'b0, 1'b1, 1'b1, 5'd9); #1;
        tot_cnt++; if (o_req_ack !== 1'b0) $display("FAIL br_busy_ack got=%b want=0", o_req_ack); else pass_cnt++;
        @(negedge clk); i_req_stb = 1'b0; #1;
        tot_cnt++; if ({m_stb, m_offset, m_page, m_tid, o_rd_rdy} !== {1'b1, 3'd3, 5'd5, 1'b0, 1'b0})
            $display("FAIL br_undisturbed got=%b want=%b", {m_stb, m_offset, m_page, m_tid, o_rd_rdy}, {1'b1, 3'd3, 5'd5, 1'b0, 1'b0}); else pass_cnt++;
        for (int t = 5; t <= 9; t++) @(negedge clk);
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd5); #1;
        tot_cnt++; if ({o_done, o_req_ack} !== 2'b10) $display("FAIL br_done_req got=%b want=10", {o_done, o_req_ack}); else pass_cnt++;
        @(negedge clk); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL br_after_done_ack got=%b want=1", o_req_ack); else pass_cnt++;
        @(negedge clk); i_req_stb = 1'b0; #1;
        tot_cnt++; if ({m_stb, m_wen, m_offset} !== 5'b10000) $display("FAIL br_new_start got=%b want=10000", {m_stb, m_wen, m_offset}); else pass_cnt++;
        for (int t = 2; t <= 9; t++) @(negedge clk);
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_done_wb} !== 2'b10) $display("FAIL br_new_done got=%b want=10", {o_done, o_done_wb}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        preload(1'b0, 1'b0, 5'd7, 64'hA7A6A5A4A3A2A1A0, 8'h81);
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd7);
        for (int t = 1; t <= 5; t++) begin
            @(negedge clk); i_req_stb = 1'b0;
        end
        #1;
        tot_cnt++; if ({m_stb, m_offset} !== 4'b1100) $display("FAIL rm_offset4 got=%b want=1100", {m_stb, m_offset}); else pass_cnt++;
        rst = 1'b1; #1;
        tot_cnt++; if ({m_stb, m_wen, o_busy, o_done, o_wr_stb, o_rd_rdy, m_offset, m_page, m_data, o_wr_ben, o_wr_data} !== '0)
            $display("FAIL rm_outputs_zero got=%b/%0d/%0d/%h", {m_stb, m_wen, o_busy, o_done, o_wr_stb, o_rd_rdy}, m_offset, m_page, o_wr_ben); else pass_cnt++;
        @(negedge clk); rst = 1'b0; #1;
        tot_cnt++; if ({o_done, o_busy} !== 2'b00) $display("FAIL rm_no_done got=%b want=00", {o_done, o_busy}); else pass_cnt++;
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_busy, m_stb} !== 3'b000) $display("FAIL rm_idle got=%b want=000", {o_done, o_busy, m_stb}); else pass_cnt++;
        @(negedge clk); drive_req(1'b1, 1'b0, 1'b0, 5'd7); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL rm_reissue_ack got=%b want=1", o_req_ack); else pass_cnt++;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk); i_req_stb = 1'b0;
        end
        @(negedge clk); i_wr_ack = 1'b1; #1;
        tot_cnt++; if ({o_wr_stb, o_wr_ben, o_wr_data} !== {1'b1, 8'h81, 64'hA7A6A5A4A3A2A1A0})
            $display("FAIL rm_wr got=%b/%h/%h want=1/81/a7a6a5a4a3a2a1a0", o_wr_stb, o_wr_ben, o_wr_data); else pass_cnt++;
        @(negedge clk); i_wr_ack = 1'b0; #1;
        tot_cnt++; if ({o_done, o_done_wb, o_wr_stb} !== 3'b110) $display("FAIL rm_done got=%b want=110", {o_done, o_done_wb, o_wr_stb}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_byte;
        preload(1'b1, 1'b0, 5'd9, 64'h3736353433323130, 8'h0F);
        @(negedge clk); drive_req(1'b1, 1'b1, 1'b0, 5'd9); #1;
        tot_cnt++; if (o_req_ack !== 1'b1) $display("FAIL bb_flush_ack got=%b want=1", o_req_ack); else pass_cnt++;
        @(negedge clk); i_req_stb = 1'b0; #1;
        tot_cnt++; if ({m_tid, m_wid, m_page} !== {1'b1, 1'b0, 5'd9}) $display("FAIL bb_flush_line got=%b want=%b", {m_tid, m_wid, m_page}, {1'b1, 1'b0, 5'd9}); else pass_cnt++;
        for (int t = 2; t <= 9; t++) @(negedge clk);
        @(negedge clk); i_wr_ack = 1'b1; #1;
        tot_cnt++; if ({o_wr_stb, o_wr_ben, o_wr_data} !== {1'b1, 8'h0F, 64'h3736353433323130})
            $display("FAIL bb_flush_wr got=%b/%h/%h want=1/0f/3736353433323130", o_wr_stb, o_wr_ben, o_wr_data); else pass_cnt++;
        @(negedge clk); i_wr_ack = 1'b0; #1;
        tot_cnt++; if ({o_done, o_done_wb, m_page} !== {2'b11, 5'd9}) $display("FAIL bb_flush_done got=%b want=%b", {o_done, o_done_wb, m_page}, {2'b11, 5'd9}); else pass_cnt++;
        @(negedge clk); drive_req(1'b0, 1'b0, 1'b1, 5'd2); #1;
        tot_cnt++; if ({o_req_ack, m_tid, m_wid, m_page} !== {1'b1, 1'b1, 1'b0, 5'd9})
            $display("FAIL bb_fill_ack got=%b want=%b", {o_req_ack, m_tid, m_wid, m_page}, {1'b1, 1'b1, 1'b0, 5'd9}); else pass_cnt++;
        @(negedge clk); i_req_stb = 1'b0; i_rd_stb = 1'b1; i_rd_data = 64'h0102030405060708; #1;
        tot_cnt++; if ({o_rd_rdy, m_tid, m_wid, m_page} !== {1'b1, 1'b0, 1'b1, 5'd2})
            $display("FAIL bb_fill_line got=%b want=%b", {o_rd_rdy, m_tid, m_wid, m_page}, {1'b1, 1'b0, 1'b1, 5'd2}); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); i_rd_stb = 1'b0; i_rd_data = '0; #1;
            exp_byte = 8'(8 - k);
            tot_cnt++; if ({m_stb, m_wen, m_offset, m_data} !== {1'b1, 1'b1, 3'(k), exp_byte})
                $display("FAIL bb_fill_write_%0d got=%b/%0d/%h want=11/%0d/%h", k, {m_stb, m_wen}, m_offset, m_data, k, exp_byte); else pass_cnt++;
        end
        @(negedge clk); #1;
        tot_cnt++; if ({o_done, o_done_wb} !== 2'b10) $display("FAIL bb_fill_done got=%b want=10", {o_done, o_done_wb}); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_flush_dirty();
        test_flush_clean();
        test_fill();
        test_busy_req();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
